// File: rtl/eros_obi_arbiter.sv
// rtl/eros_obi_arbiter.sv - Round-robin N:1 OBI arbiter with in-order response routing
// Optional stall counters: define EROS_OBI_ARB_PERF_EN.
package eros_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module eros_obi_arbiter
  import eros_obi_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  mst_req_i  [NUM_MASTERS],
  output obi_resp_t mst_resp_o [NUM_MASTERS],
  output obi_req_t  slv_req_o,
  input  obi_resp_t slv_resp_i,
`ifdef EROS_OBI_ARB_PERF_EN
  input  logic        perf_clr_i,
  output logic [31:0] stall_cnt_o [NUM_MASTERS],
`endif
  output logic      err_o
);
  localparam int IDX_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             win_vld, full, hs, pop;
  logic [IDX_W-1:0] win_idx, cand, head;

  always_comb begin
    win_vld = lock_q;
    win_idx = lock_idx_q;
    cand    = '0;
    if (!lock_q) begin
      for (int off = 0; off < NUM_MASTERS; off++) begin
        if (int'(rr_ptr_q) + off >= NUM_MASTERS) cand = IDX_W'(int'(rr_ptr_q) + off - NUM_MASTERS);
        else                                     cand = IDX_W'(int'(rr_ptr_q) + off);
        if (!win_vld && mst_req_i[cand].req) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    if (!rst_i && win_vld && !full) begin
      slv_req_o = mst_req_i[win_idx];
    end else begin
      slv_req_o     = mst_req_i[0];
      slv_req_o.req = 1'b0;
    end
  end

  assign hs  = slv_req_o.req & slv_resp_i.gnt;
  assign pop = !rst_i && slv_resp_i.rvalid && (cnt_q != '0);

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mst_resp_o[i].rdata  = slv_resp_i.rdata;
      mst_resp_o[i].gnt    = hs && (win_idx == IDX_W'(i));
      mst_resp_o[i].rvalid = pop && (head == IDX_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (hs) begin
      fifo_d[wr_ptr_q] = win_idx;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
      lock_d   = 1'b0;
    end else if (slv_req_o.req) begin
      // OBI forbids retracting an ungranted request, so pin the winner.
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (slv_resp_i.rvalid && (cnt_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef EROS_OBI_ARB_PERF_EN
  logic [31:0] stall_cnt_q [NUM_MASTERS];
  logic [31:0] stall_cnt_d [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      stall_cnt_d[i] = stall_cnt_q[i];
      if (perf_clr_i) begin
        stall_cnt_d[i] = '0;
      end else if (mst_req_i[i].req && !mst_resp_o[i].gnt && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MASTERS; i++) stall_cnt_q[i] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_eros_obi_arbiter.sv
// tb/tb_eros_obi_arbiter.sv - Directed self-checking bench for eros_obi_arbiter
module tb_eros_obi_arbiter;
  import eros_obi_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  mst_req  [2];
  obi_resp_t mst_resp [2];
  obi_req_t  slv_req;
  obi_resp_t slv_resp;
  logic      err;
`ifdef EROS_OBI_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cnt [2];
`endif

  int checks = 0;
  int errors = 0;

  eros_obi_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mst_req_i  (mst_req),
    .mst_resp_o (mst_resp),
    .slv_req_o  (slv_req),
    .slv_resp_i (slv_resp),
`ifdef EROS_OBI_ARB_PERF_EN
    .perf_clr_i (perf_clr),
    .stall_cnt_o(stall_cnt),
`endif
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic r, input logic [31:0] a);
    mst_req[m].req   = r;
    mst_req[m].we    = 1'b0;
    mst_req[m].be    = 4'hF;
    mst_req[m].addr  = a;
    mst_req[m].wdata = 32'h0;
  endtask

  task automatic slave(input logic g, input logic rv, input logic [31:0] rd);
    slv_resp.gnt    = g;
    slv_resp.rvalid = rv;
    slv_resp.rdata  = rd;
  endtask

  // gnt0, gnt1, rvalid0, rvalid1 packed for compact checks
  function automatic logic [3:0] hs_vec();
    return {mst_resp[0].gnt, mst_resp[1].gnt, mst_resp[0].rvalid, mst_resp[1].rvalid};
  endfunction

  initial begin
    rst = 1'b1;
`ifdef EROS_OBI_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    set_req(0, 1'b1, 32'h100);
    set_req(1, 1'b0, 32'h200);
    slave(1'b1, 1'b1, 32'h55);
    cyc(); #1;
    chk("rst_slv_req", slv_req.req, 1'b0);
    chk("rst_mst_hs", hs_vec(), 4'b0000);
    cyc(); #1;
    chk("rst_err", err, 1'b0);

    // Fairness: both requesting, grants alternate starting with master 0
    rst = 1'b0;
    set_req(0, 1'b1, 32'h100);
    set_req(1, 1'b1, 32'h200);
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("fair_a_addr", slv_req.addr, 32'h100);
    chk("fair_a_hs", hs_vec(), 4'b1000);
    cyc();
    slave(1'b1, 1'b1, 32'hA0);
    #1;
    chk("fair_b_addr", slv_req.addr, 32'h200);
    chk("fair_b_hs", hs_vec(), 4'b0110);
    chk("fair_b_rdata", mst_resp[0].rdata, 32'hA0);
    cyc();
    slave(1'b1, 1'b1, 32'hA1);
    #1;
    chk("fair_c_hs", hs_vec(), 4'b1001);
    chk("fair_c_rdata", mst_resp[1].rdata, 32'hA1);
    cyc();
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'hA2);
    #1;
    chk("fair_d_hs", hs_vec(), 4'b0010);
    chk("fair_d_req", slv_req.req, 1'b0);
    cyc();
    // One master-1 transaction moves the pointer back to master 0
    set_req(1, 1'b1, 32'h300);
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("rr_e_hs", hs_vec(), 4'b0100);
    cyc();
    set_req(1, 1'b0, 32'h0);
    slave(1'b0, 1'b1, 32'hB0);
    #1;
    chk("rr_f_hs", hs_vec(), 4'b0001);
    chk("simul_no_err", err, 1'b0);
    cyc();

    // Lock: master 1 presented and not granted stays presented
    set_req(1, 1'b1, 32'h1000);
    slave(1'b0, 1'b0, 32'h0);
    #1;
    chk("lock_1_addr", slv_req.addr, 32'h1000);
    chk("lock_1_hs", hs_vec(), 4'b0000);
    cyc();
    set_req(0, 1'b1, 32'h2000);
    #1;
    chk("lock_2_addr", slv_req.addr, 32'h1000);
    cyc(); #1;
    chk("lock_3_addr", slv_req.addr, 32'h1000);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("lock_4_addr", slv_req.addr, 32'h1000);
    chk("lock_4_hs", hs_vec(), 4'b0100);
    cyc();
    set_req(1, 1'b0, 32'h0);
    slave(1'b1, 1'b1, 32'hC1);
    #1;
    chk("lock_5_addr", slv_req.addr, 32'h2000);
    chk("lock_5_hs", hs_vec(), 4'b1001);
    cyc();
    set_req(0, 1'b0, 32'h0);
    slave(1'b0, 1'b1, 32'hC0);
    #1;
    chk("lock_6_hs", hs_vec(), 4'b0010);
    cyc();

    // Back-pressure: two outstanding, third waits until the cycle after a pop
    set_req(0, 1'b1, 32'h400);
    set_req(1, 1'b1, 32'h500);
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("bp_1_hs", hs_vec(), 4'b0100);
    cyc(); #1;
    chk("bp_2_hs", hs_vec(), 4'b1000);
    cyc(); #1;
    chk("bp_3_req", slv_req.req, 1'b0);
    chk("bp_3_hs", hs_vec(), 4'b0000);
    cyc();
    slave(1'b1, 1'b1, 32'hD1);
    #1;
    chk("bp_4_req", slv_req.req, 1'b0);
    chk("bp_4_hs", hs_vec(), 4'b0001);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("bp_5_hs", hs_vec(), 4'b0100);
    cyc();
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    slave(1'b0, 1'b1, 32'hD0);
    #1;
    chk("bp_6_hs", hs_vec(), 4'b0010);
    cyc(); #1;
    chk("bp_7_hs", hs_vec(), 4'b0001);
    cyc();

    // Response with empty FIFO
    slave(1'b0, 1'b1, 32'hEE);
    #1;
    chk("err_drop_hs", hs_vec(), 4'b0000);
    chk("err_before", err, 1'b0);
    cyc();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    chk("err_set", err, 1'b1);
    cyc(); #1;
    chk("err_sticky", err, 1'b1);

    // Reset with two outstanding
    set_req(0, 1'b1, 32'h600);
    set_req(1, 1'b1, 32'h700);
    slave(1'b1, 1'b0, 32'h0);
    #1;
    chk("pre_rst_hs0", hs_vec(), 4'b1000);
    cyc(); #1;
    chk("pre_rst_hs1", hs_vec(), 4'b0100);
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", slv_req.req, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_rr", hs_vec(), 4'b1000);
    cyc(); #1;
    chk("post_rst_cnt1", hs_vec(), 4'b0100);
    cyc(); #1;
    chk("post_rst_full", slv_req.req, 1'b0);

`ifdef EROS_OBI_ARB_PERF_EN
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    slave(1'b0, 1'b0, 32'h0);
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h800);
    set_req(1, 1'b1, 32'h900);
    repeat (5) cyc();
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    #1;
    chk("perf_stall1", stall_cnt[1], 32'd5);
    chk("perf_stall0", stall_cnt[0], 32'd5);
    set_req(1, 1'b1, 32'h900);
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    set_req(1, 1'b0, 32'h0);
    #1;
    chk("perf_clr", stall_cnt[1], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
